// File: rtl/matrix_denormalization.sv
//------------------------------------------------------------------------------
// Module      : matrix_denormalization
// Description : Rebuilds a SIZE x SIZE matrix of signed values from unsigned
//               normalized codes: out = min + (q * (max - min)) / (2^WIDTH_IN-1).
//               Captures min/max on start, computes the range in one cycle,
//               then writes one element per cycle in row-major order.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-low reset
//               start      - begin one matrix (ignored while busy)
//               min_val    - signed minimum of the original range
//               max_val    - signed maximum of the original range
//               matrix_in  - normalized input codes, sampled per element
//               busy       - high while a matrix is in flight
//               done       - one-cycle pulse when the last element is written
//               matrix_out - registered reconstructed matrix
// Config      : MATRIX_DENORM_ROUNDING_EN - when defined the quotient is
//               rounded to nearest instead of truncated (timing unchanged).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module matrix_denormalization #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  parameter int SIZE      = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [WIDTH_OUT-1:0] min_val,
  input  logic signed [WIDTH_OUT-1:0] max_val,
  input  logic        [WIDTH_IN-1:0]  matrix_in  [SIZE][SIZE],
  output logic                        busy,
  output logic                        done,
  output logic signed [WIDTH_OUT-1:0] matrix_out [SIZE][SIZE]
);

  localparam int CNT_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int RANGE_W = WIDTH_OUT + 1;
  localparam int PROD_W  = WIDTH_IN + RANGE_W;

  // Full-scale code (255 for 8-bit inputs) is the divisor.
  localparam logic [PROD_W-1:0] C_QMAX = PROD_W'((1 << WIDTH_IN) - 1);
`ifdef MATRIX_DENORM_ROUNDING_EN
  localparam logic [PROD_W-1:0] C_BIAS = (C_QMAX - 1) >> 1;
`else
  localparam logic [PROD_W-1:0] C_BIAS = '0;
`endif

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SIZE - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_CALC_RANGE = 2'd1;
  localparam logic [1:0] S_DENORM     = 2'd2;

  logic [1:0]                  r_state;
  logic [1:0]                  w_next;
  logic                        w_capture;
  logic                        w_calc;
  logic                        w_write;
  logic                        w_last;

  logic signed [WIDTH_OUT-1:0] r_min;
  logic signed [WIDTH_OUT-1:0] r_max;
  logic signed [RANGE_W-1:0]   r_range;
  logic [CNT_W-1:0]            r_row;
  logic [CNT_W-1:0]            r_col;
  logic                        r_done;
  logic signed [WIDTH_OUT-1:0] r_out [SIZE][SIZE];

  logic signed [RANGE_W-1:0]   w_diff;
  logic [WIDTH_IN-1:0]         w_q;
  logic [PROD_W-1:0]           w_prod;
  logic [WIDTH_OUT-1:0]        w_quot;
  logic signed [WIDTH_OUT-1:0] w_elem;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = S_CALC_RANGE;
      S_CALC_RANGE: w_next = S_DENORM;
      S_DENORM:     if (w_last) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs / strobes
  //--------------------------------------------------------------------------
  always_comb begin
    w_capture = 1'b0;
    w_calc    = 1'b0;
    w_write   = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:       w_capture = start;
      S_CALC_RANGE: begin
        w_calc = 1'b1;
        busy   = 1'b1;
      end
      S_DENORM: begin
        w_write = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_last = w_write && (r_row == C_LAST) && (r_col == C_LAST);
  assign done   = r_done;

  //--------------------------------------------------------------------------
  // Datapath
  //--------------------------------------------------------------------------
  // Sign-extend both bounds by one bit so the difference cannot wrap.
  assign w_diff = {r_max[WIDTH_OUT-1], r_max} - {r_min[WIDTH_OUT-1], r_min};

  assign w_q    = matrix_in[r_row][r_col];
  assign w_prod = PROD_W'(w_q) * PROD_W'($unsigned(r_range));
  // Quotient never exceeds range, so it fits WIDTH_OUT bits and the sum
  // below stays within [min, max] without overflow.
  assign w_quot = WIDTH_OUT'((w_prod + C_BIAS) / C_QMAX);
  assign w_elem = r_min + $signed(w_quot);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_min   <= '0;
      r_max   <= '0;
      r_range <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_capture) begin
        r_min <= min_val;
        r_max <= max_val;
        r_row <= '0;
        r_col <= '0;
      end
      if (w_calc) begin
        // Inverted bounds collapse to a zero range: every output = min.
        r_range <= w_diff[RANGE_W-1] ? '0 : w_diff;
      end
      if (w_write) begin
        if (r_col == C_LAST) begin
          r_col <= '0;
          r_row <= (r_row == C_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Only the addressed element is rewritten; others keep their value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          r_out[i][j] <= '0;
        end
      end
    end else if (w_write) begin
      r_out[r_row][r_col] <= w_elem;
    end
  end

  assign matrix_out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_matrix_denormalization.sv
//------------------------------------------------------------------------------
// Module      : tb_matrix_denormalization
// Description : Directed self-checking bench for matrix_denormalization.
//               Define MATRIX_DENORM_ROUNDING_EN for both files together.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_matrix_denormalization;

  localparam int WI = 8;
  localparam int WO = 16;
  localparam int N  = 10;

`ifdef MATRIX_DENORM_ROUNDING_EN
  localparam int E_Q128 = 4;
  localparam int E_Q1   = -992;
  localparam int E_Q64  = -498;
`else
  localparam int E_Q128 = 3;
  localparam int E_Q1   = -993;
  localparam int E_Q64  = -499;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic signed [WO-1:0] min_val;
  logic signed [WO-1:0] max_val;
  logic        [WI-1:0] matrix_in  [N][N];
  logic                 busy;
  logic                 done;
  logic signed [WO-1:0] matrix_out [N][N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_denormalization #(
    .WIDTH_IN  (WI),
    .WIDTH_OUT (WO),
    .SIZE      (N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .min_val    (min_val),
    .max_val    (max_val),
    .matrix_in  (matrix_in),
    .busy       (busy),
    .done       (done),
    .matrix_out (matrix_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for exactly one edge (edge E); returns 1 ns after E.
  task automatic go(input int lo, input int hi);
    min_val = WO'(lo);
    max_val = WO'(hi);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Counts edges until done is seen, bounded by budget.
  task automatic wait_done(input int budget, output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    while (edges < budget) begin
      tick();
      edges++;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic signed [WO-1:0] e16;
    reset   = 1'b0;
    start   = 1'b0;
    min_val = '0;
    max_val = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) matrix_in[i][j] = '0;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    e16 = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (matrix_out[i][j] !== e16) begin
          errors++;
          $display("FAIL reset_out[%0d][%0d]: got %0d want 0", i, j, matrix_out[i][j]);
        end
      end
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_scaling();
    int  edges;
    bit  ok;
    int  expv [N][N];
    logic signed [WO-1:0] e16;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        matrix_in[i][j] = 8'd255;
        expv[i][j]      = 1000;
      end
    matrix_in[0][0] = 8'd0;   expv[0][0] = -1000;
    matrix_in[0][2] = 8'd128; expv[0][2] = E_Q128;
    matrix_in[0][3] = 8'd1;   expv[0][3] = E_Q1;
    matrix_in[0][4] = 8'd64;  expv[0][4] = E_Q64;
    go(-1000, 1000);
    wait_done(200, edges, ok);
    checks++;
    if (!ok || edges != 101) begin
      errors++;
      $display("FAIL scaling_latency: got %0d edges (done seen=%0b) want 101", edges, ok);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e16 = WO'(expv[i][j]);
        checks++;
        if (matrix_out[i][j] !== e16) begin
          errors++;
          $display("FAIL scaling_out[%0d][%0d]: got %0d want %0d", i, j, matrix_out[i][j], e16);
        end
      end
  endtask

  // min==max pass with start held high, then a second request accepted in
  // the idle cycle right after done with inverted bounds.
  task automatic test_back_to_back();
    int  edges;
    bit  ok;
    logic signed [WO-1:0] e16;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) matrix_in[i][j] = 8'($urandom_range(255));
    min_val = 16'sd500;
    max_val = 16'sd500;
    start   = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_first: got %b want 1", busy); end
    wait_done(200, edges, ok);
    checks++;
    if (!ok || edges != 101) begin
      errors++;
      $display("FAIL b2b_latency_first: got %0d edges (done seen=%0b) want 101", edges, ok);
    end
    e16 = 16'sd500;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (matrix_out[i][j] !== e16) begin
          errors++;
          $display("FAIL equal_bounds_out[%0d][%0d]: got %0d want 500", i, j, matrix_out[i][j]);
        end
      end
    min_val = 16'sd100;
    max_val = 16'sd50;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) matrix_in[i][j] = 8'($urandom_range(255));
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    wait_done(200, edges, ok);
    checks++;
    if (!ok || edges != 101) begin
      errors++;
      $display("FAIL b2b_latency_second: got %0d edges (done seen=%0b) want 101", edges, ok);
    end
    e16 = 16'sd100;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (matrix_out[i][j] !== e16) begin
          errors++;
          $display("FAIL inverted_out[%0d][%0d]: got %0d want 100", i, j, matrix_out[i][j]);
        end
      end
  endtask

  // Range 255 makes out == q; previous outputs are all 100.
  task automatic test_timing();
    logic signed [WO-1:0] e16;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) matrix_in[i][j] = 8'(i * 10 + j + 150);
    go(0, 255);
    for (int e = 0; e <= 100; e++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL timing_busy_edge%0d: got busy=%b done=%b want busy=1 done=0", e, busy, done);
      end
      if (e == 1) begin
        checks++;
        if (matrix_out[0][0] !== 16'sd100) begin
          errors++;
          $display("FAIL timing_00_early: got %0d want 100", matrix_out[0][0]);
        end
      end
      if (e == 2) begin
        checks++;
        if (matrix_out[0][0] !== 16'sd150) begin
          errors++;
          $display("FAIL timing_00_write: got %0d want 150", matrix_out[0][0]);
        end
        checks++;
        if (matrix_out[0][1] !== 16'sd100) begin
          errors++;
          $display("FAIL timing_01_retain: got %0d want 100", matrix_out[0][1]);
        end
      end
      if (e == 100) begin
        checks++;
        if (matrix_out[9][9] !== 16'sd100) begin
          errors++;
          $display("FAIL timing_99_early: got %0d want 100", matrix_out[9][9]);
        end
      end
      if (e != 100) tick();
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timing_edge101: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    checks++;
    if (matrix_out[9][9] !== 16'sd249) begin
      errors++;
      $display("FAIL timing_99_write: got %0d want 249", matrix_out[9][9]);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL timing_done_clear: got %b want 0", done); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e16 = WO'(i * 10 + j + 150);
        checks++;
        if (matrix_out[i][j] !== e16) begin
          errors++;
          $display("FAIL timing_out[%0d][%0d]: got %0d want %0d", i, j, matrix_out[i][j], e16);
        end
      end
  endtask

  task automatic test_ignore_start();
    int  edges;
    bit  ok;
    logic signed [WO-1:0] e16;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) matrix_in[i][j] = 8'(255 - (i * 10 + j));
    go(0, 255);
    for (int k = 1; k < 50; k++) tick();
    min_val = -16'sd1000;
    max_val = 16'sd1000;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", busy); end
    wait_done(200, edges, ok);
    checks++;
    if (!ok || edges != 51) begin
      errors++;
      $display("FAIL ignore_latency: got %0d edges after edge 50 (done seen=%0b) want 51", edges, ok);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e16 = WO'(255 - (i * 10 + j));
        checks++;
        if (matrix_out[i][j] !== e16) begin
          errors++;
          $display("FAIL ignore_out[%0d][%0d]: got %0d want %0d", i, j, matrix_out[i][j], e16);
        end
      end
  endtask

  task automatic test_reset_abort();
    int  edges;
    bit  ok;
    logic signed [WO-1:0] e16;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) matrix_in[i][j] = 8'((i + j) * 5);
    go(0, 255);
    for (int k = 1; k <= 51; k++) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: got busy=%b done=%b want 0 0", busy, done);
    end
    e16 = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (matrix_out[i][j] !== e16) begin
          errors++;
          $display("FAIL abort_out[%0d][%0d]: got %0d want 0", i, j, matrix_out[i][j]);
        end
      end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", done); end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) matrix_in[i][j] = 8'(i * 7 + j * 3 + 40);
    reset   = 1'b1;
    min_val = -16'sd100;
    max_val = 16'sd155;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart_busy: got %b want 1", busy); end
    wait_done(200, edges, ok);
    checks++;
    if (!ok || edges != 101) begin
      errors++;
      $display("FAIL abort_restart_latency: got %0d edges (done seen=%0b) want 101", edges, ok);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e16 = WO'(i * 7 + j * 3 + 40 - 100);
        checks++;
        if (matrix_out[i][j] !== e16) begin
          errors++;
          $display("FAIL abort_restart_out[%0d][%0d]: got %0d want %0d", i, j, matrix_out[i][j], e16);
        end
      end
  endtask

  initial begin
    test_reset();
    test_scaling();
    test_back_to_back();
    test_timing();
    test_ignore_start();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
